// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Handshake bundle between the decode stage, the immediate
//               generator and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [2:0]            immSrc;
    logic                  zeroExt;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] immOp;
    logic                  illegal;

    // Producer/consumer side that drives instructions and accepts results
    modport master (
        output flush, in_valid, instr, immSrc, zeroExt, out_ready,
        input  in_ready, out_valid, immOp, illegal
    );

    // Immediate generator side
    modport slave (
        input  flush, in_valid, instr, immSrc, zeroExt, out_ready,
        output in_ready, out_valid, immOp, illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : RV32I immediate generator (I/S/B/U/J/SHAMT) with sign/zero
//               extension to DATA_WIDTH, behind a one-cycle output register
//               and a one-entry skid register with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [2:0] F_I     = 3'b000;
    localparam logic [2:0] F_S     = 3'b001;
    localparam logic [2:0] F_B     = 3'b010;
    localparam logic [2:0] F_U     = 3'b011;
    localparam logic [2:0] F_J     = 3'b100;
    localparam logic [2:0] F_SHAMT = 3'b101;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] out_imm_q;
    logic                  out_ill_q;
    logic [DATA_WIDTH-1:0] skid_imm_q;
    logic                  skid_ill_q;

    logic                  sgn;
    logic [31:0]           imm32;
    logic                  hi_fill;
    logic                  ill_new;
    logic [DATA_WIDTH-1:0] ext_new;

    logic                  accept;
    logic                  pop;
    logic                  load_out_new;
    logic                  load_out_skid;
    logic                  load_skid;

    // instr[6:0] is the opcode; format selection comes from immSrc instead
    logic                  unused_opcode;
    assign unused_opcode = ^bus.instr[6:0];

    // Assemble the 32-bit immediate and the fill bit for anything above 31
    always_comb begin
        sgn     = bus.zeroExt ? 1'b0 : bus.instr[31];
        imm32   = 32'd0;
        hi_fill = 1'b0;
        ill_new = 1'b0;
        case (bus.immSrc)
            F_I: begin
                imm32   = {{20{sgn}}, bus.instr[31:20]};
                hi_fill = sgn;
            end
            F_S: begin
                imm32   = {{20{sgn}}, bus.instr[31:25], bus.instr[11:7]};
                hi_fill = sgn;
            end
            F_B: begin
                imm32   = {{19{sgn}}, bus.instr[31], bus.instr[7],
                           bus.instr[30:25], bus.instr[11:8], 1'b0};
                hi_fill = sgn;
            end
            F_U: begin
                // U already occupies bit 31, so zeroExt only affects the upper fill
                imm32   = {bus.instr[31:12], 12'd0};
                hi_fill = sgn;
            end
            F_J: begin
                imm32   = {{11{sgn}}, bus.instr[31], bus.instr[19:12],
                           bus.instr[20], bus.instr[30:21], 1'b0};
                hi_fill = sgn;
            end
            F_SHAMT: begin
                imm32   = {27'd0, bus.instr[24:20]};
                hi_fill = 1'b0;
            end
            default: begin
                ill_new = 1'b1;
            end
        endcase
    end

    // A zero-width replication is illegal, so the exact-32 case is split out
    generate
        if (DATA_WIDTH > 32) begin : g_ext_wide
            assign ext_new = {{(DATA_WIDTH-32){hi_fill}}, imm32};
        end else begin : g_ext_exact
            logic unused_hi;
            assign unused_hi = hi_fill;
            assign ext_new   = imm32;
        end
    endgenerate

    assign bus.in_ready  = (state_q != S_TWO);
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.immOp     = out_imm_q;
    assign bus.illegal   = out_ill_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    // Buffer occupancy control; flush overrides every transition and load
    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d      = S_ONE;
                        load_out_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        state_d       = S_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and skid data registers; the skid entry always drains first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_imm_q <= ext_new;
                out_ill_q <= ill_new;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= ext_new;
                skid_ill_q <= ill_new;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I datapath: takes a 32-bit instruction word and an immediate-format select, reconstructs the immediate for all five base formats (I, S, B, U, J) plus shift-amount, and sign- or zero-extends it to `DATA_WIDTH`. A one-cycle registered stage with a two-entry skid buffer and valid/ready handshake decouples the decode stage from the execute stage. It replaces the single-format combinational extender as the decode-stage immediate source.

## Interface
- `DATA_WIDTH`, 32, output width; legal values are 32 or larger; bits above 31 replicate bit 31 of the 32-bit result, or are zero when `zeroExt`=1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of all buffered entries.
- `in_valid`  in  1  the instruction and controls are valid.
- `in_ready`  out  1  the block can accept an entry this cycle.
- `instr`  in  32  instruction word.
- `immSrc`  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110/111 illegal.
- `zeroExt`  in  1  when 1, zero-extend instead of sign-extend (I/S/B/J only).
- `out_valid`  out  1  `immOp`/`illegal` are valid.
- `out_ready`  in  1  the consumer accepts the current output.
- `immOp`  out  `DATA_WIDTH`  extended immediate.
- `illegal`  out  1  the entry had an illegal `immSrc`.

## Operation
- Immediate assembly (32-bit), before extension:
  - I: `instr[31:20]`
  - S: `{instr[31:25], instr[11:7]}`
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}` (13 bits)
  - U: `{instr[31:12], 12'b0}`, never zero-extended within 32 bits
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}` (21 bits)
  - SHAMT: `instr[24:20]`, always zero-extended
- Extension:
  - I/S/B/J: the MSB of the field fills up to `DATA_WIDTH-1`, unless `zeroExt`=1, in which case the fill is 0.
  - U with `zeroExt`=1: bits above 31 are 0.
- Illegal `immSrc` (110/111): the entry is stored with `immOp`=0 and `illegal`=1. It is still handshaken normally.
- Accept condition: `in_valid && in_ready`. Pop condition: `out_valid && out_ready`.
- Buffer FSM (the output register plus one skid register):
  - EMPTY: accept → ONE (output register loaded).
  - ONE: accept&pop → ONE (output register reloaded); accept&!pop → TWO (skid register loaded); !accept&pop → EMPTY; otherwise hold.
  - TWO: pop → ONE (skid register moves to the output register); otherwise hold. No accept is possible in this state.
- Outputs:
  - `in_ready` = (state != TWO), decoded from the state register only. There is no combinational path from `out_ready`.
  - `out_valid` = (state != EMPTY).
- Ordering: strict FIFO. The skid entry is always older than any newly accepted entry.
- `flush` has priority over everything: next state EMPTY, `out_valid`=0, and any accept in the same cycle is dropped. `immOp`/`illegal` register contents are don't-care after a flush, but must not be presented as valid.
- While `out_valid`=1 and `out_ready`=0, `immOp` and `illegal` hold stable.

## Timing
- Reset (asynchronous, takes effect immediately): state EMPTY, `out_valid`=0, `in_ready`=1, `immOp`=0, `illegal`=0, skid register=0.
- After `rst` deasserts, the first accept can occur at the first rising edge.
- Latency: an entry accepted at edge N appears with `out_valid`=1 after edge N (one cycle) when the buffer was EMPTY, or when ONE with a simultaneous pop.
- Throughput: one entry per cycle while `out_ready`=1.
- A single `out_ready` low cycle with continuous input fills the skid register. `in_ready` drops the cycle after that edge and returns the cycle after the next pop.
- Reset mid-operation: all entries are lost and outputs return to reset values asynchronously.
- Simultaneous flush and pop: the pop is consumed by the downstream, and the block is EMPTY next cycle.

## Test plan
- Reset: assert `rst` mid-stream with TWO entries buffered → `out_valid`=0, `in_ready`=1, `immOp`=0 immediately; the next accept appears one cycle later.
- Formats (`DATA_WIDTH`=32, `out_ready`=1, back-to-back):
  - I `0xFFF00093` → `0xFFFFFFFF`
  - S `0xFE102C23` → `0xFFFFFFF8`
  - B `0xFE000EE3` → `0xFFFFFFFC`
  - U `0x12345037` → `0x12345000`
  - SHAMT `0x01F09093` → `0x0000001F`
  - Each result appears exactly one cycle after accept, in order.
- Zero-extend and width:
  - I `0xFFF00093` with `zeroExt`=1 → `0x00000FFF`.
  - With `DATA_WIDTH`=64: same instruction, `zeroExt`=0 → `0xFFFFFFFFFFFFFFFF`; U `0x80000037` with `zeroExt`=1 → `0x0000000080000000`.
- Backpressure: stream A, B, C with `out_ready`=0 for 2 cycles → state TWO and `in_ready`=0 while A is held stable; on release, output order is A, B, C with no loss or duplication.
- Illegal plus flush:
  - `immSrc`=110 → `illegal`=1, `immOp`=0, entry handshaken.
  - `flush` asserted in TWO with `in_valid`=1 → EMPTY next cycle, input dropped, `in_ready`=1.
